seq_scan_ctrl: RTL and testbench
================================

SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, number of bits per scan word (WIDTH >= 3).
REQ-002 Parameter: CW, default 4, width of match_cnt; CW SHALL be at least clog2(WIDTH/2)+1.
REQ-003 One clock; reset is asynchronous and active-high; the ports SHALL be named clk and rst.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request to scan data_in; sampled only in IDLE.
REQ-007 data_in  input  WIDTH  word to scan; captured on the accepting edge.
REQ-008 hold  input  1  freezes shifting while high in SHIFT.
REQ-009 abort  input  1  terminates the scan in SHIFT without done.
REQ-010 ser_out  output  1  current serial bit, LSB first.
REQ-011 ser_valid  output  1  ser_out is consumed at this edge.
REQ-012 hit  output  1  Mealy 101-detect on the current bit (combinational).
REQ-013 busy  output  1  high in SHIFT.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 match_cnt  output  CW  number of 101 matches in the word.
REQ-016 match_pos  output  WIDTH  bit i set if a match ended on bit i.

Function
REQ-017 The controller FSM SHALL have states IDLE, SHIFT and DONE.
REQ-018 In IDLE with start=1, the block SHALL capture data_in, clear idx, match_cnt, match_pos and the detector, and enter SHIFT at that edge.
REQ-019 In SHIFT, ser_out SHALL equal word[idx], and ser_valid SHALL equal !hold && !abort.
REQ-020 When ser_valid=1, the bit SHALL be consumed at the edge: idx increments and the detector advances.
REQ-021 The embedded detector SHALL be an overlapping Mealy 101 detector with states D0 (none), D1 (seen 1) and D10 (seen 10).
REQ-022 Detector transitions: D0 -1->D1, D0 -0->D0; D1 -1->D1, D1 -0->D10; D10 -1->D1 with hit, D10 -0->D0.
REQ-023 hit SHALL be 1 only when ser_valid=1, the detector state is D10, and ser_out=1.
REQ-024 On a consumed bit with hit=1, match_cnt SHALL increment by 1 (no wrap is possible for legal CW) and match_pos[idx] SHALL be set.
REQ-025 The detector SHALL be reset at each accepted start; matches SHALL NOT span words.
REQ-026 When the bit at idx=WIDTH-1 is consumed, the FSM SHALL enter DONE.
REQ-027 In DONE, done=1 for exactly one cycle, after which the FSM returns to IDLE unconditionally.
REQ-028 With no hold, done SHALL be high in cycle N+WIDTH+1, where the start was accepted at edge N; each hold cycle adds one cycle.
REQ-029 While hold=1 in SHIFT, idx, the detector, match_cnt and match_pos SHALL be frozen.
REQ-030 While hold=1, ser_out SHALL stay stable.
REQ-031 abort=1 in SHIFT SHALL go to IDLE at the next edge, with priority over hold and bit consumption.
REQ-032 On abort, the block SHALL NOT pulse done and SHALL retain partial results.
REQ-033 start in SHIFT or DONE SHALL be ignored and SHALL NOT be queued.
REQ-034 abort and hold outside SHIFT SHALL be ignored.
REQ-035 busy SHALL be 1 exactly in SHIFT.
REQ-036 match_cnt and match_pos SHALL hold their values from done until the next accepted start.
REQ-037 ser_valid and hit SHALL be 0 in IDLE and DONE.

Reset
REQ-038 rst=1 SHALL immediately force the FSM to IDLE, the detector to D0, and idx to 0.
REQ-039 rst=1 SHALL immediately force busy=0, done=0, ser_valid=0, ser_out=0, hit=0, match_cnt=0 and match_pos=0.
REQ-040 Reset asserted mid-scan SHALL discard the scan with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Verification
REQ-041 Bench SHALL cover: start, data_in=8'h05 -> bits 1,0,1,0,0,0,0,0; hit on idx 2; done at N+9; match_cnt=1; match_pos=8'h04.
REQ-042 Bench SHALL cover: data_in=8'hAD (overlap) -> hits on idx 2, 5, 7; match_cnt=3; match_pos=8'hA4.
REQ-043 Bench SHALL cover: data_in=8'h55 -> match_cnt=3, match_pos=8'h54; data_in=8'hFF -> match_cnt=0, match_pos=8'h00, done still pulses.
REQ-044 Bench SHALL cover: data_in=8'h05 with hold=1 for 3 cycles at idx 1 -> ser_out held at 0 and ser_valid=0 during hold; done at N+12; results as in REQ-041.
REQ-045 Bench SHALL cover: abort at idx 4 of 8'hAD -> IDLE next edge; no done; match_cnt=1, match_pos=8'h04.
REQ-046 Bench SHALL cover: rst pulse at idx 5 -> all outputs 0 asynchronously; a new start of 8'h05 then completes per REQ-041.
REQ-047 Bench SHALL cover: start held high through SHIFT and DONE -> exactly one scan completes, and a new scan is accepted only in the following IDLE cycle.

Source files
------------

// File: rtl/seq_scan_ctrl_if.sv
// rtl/seq_scan_ctrl_if.sv - request/serial-result bundle for the 101 scan controller
interface seq_scan_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
);
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic             hold;
    logic             abort;
    logic             ser_out;
    logic             ser_valid;
    logic             hit;
    logic             busy;
    logic             done;
    logic [CW-1:0]    match_cnt;
    logic [WIDTH-1:0] match_pos;

    modport master (
        output start, data_in, hold, abort,
        input  ser_out, ser_valid, hit, busy, done, match_cnt, match_pos
    );

    modport slave (
        input  start, data_in, hold, abort,
        output ser_out, ser_valid, hit, busy, done, match_cnt, match_pos
    );
endinterface

// File: rtl/seq_scan_ctrl.sv
// rtl/seq_scan_ctrl.sv - serialises a word LSB first and counts overlapping 101 patterns
module seq_scan_ctrl #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic              clk,
    input  logic              rst,
    seq_scan_ctrl_if.slave    bus
);
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {D0, D1, D10}       det_t;

    state_t           state, state_nx;
    det_t             det, det_nx;
    logic [WIDTH-1:0] word;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    match_cnt;
    logic [WIDTH-1:0] match_pos;
    logic             ser_out, ser_valid, hit, accept, last_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            det   <= D0;
        end else begin
            state <= state_nx;
            det   <= det_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        det_nx    = det;
        ser_out   = 1'b0;
        ser_valid = 1'b0;
        hit       = 1'b0;
        accept    = 1'b0;
        last_bit  = (idx == IW'(WIDTH - 1));
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept   = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                ser_out   = word[idx];
                ser_valid = !bus.hold && !bus.abort;
                hit       = ser_valid && (det == D10) && ser_out;
                // abort wins over both hold and consuming the last bit
                if (bus.abort)
                    state_nx = IDLE;
                else if (ser_valid && last_bit)
                    state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        if (accept) begin
            det_nx = D0;
        end else if (ser_valid) begin
            case (det)
                D0:      det_nx = ser_out ? D1 : D0;
                D1:      det_nx = ser_out ? D1 : D10;
                D10:     det_nx = ser_out ? D1 : D0;
                default: det_nx = D0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word      <= '0;
            idx       <= '0;
            match_cnt <= '0;
            match_pos <= '0;
        end else if (accept) begin
            word      <= bus.data_in;
            idx       <= '0;
            match_cnt <= '0;
            match_pos <= '0;
        end else if (ser_valid) begin
            idx <= last_bit ? '0 : idx + IW'(1);
            if (hit) begin
                match_cnt      <= match_cnt + CW'(1);
                match_pos[idx] <= 1'b1;
            end
        end
    end

    assign bus.ser_out   = ser_out;
    assign bus.ser_valid = ser_valid;
    assign bus.hit       = hit;
    assign bus.busy      = (state == SHIFT);
    assign bus.done      = (state == DONE);
    assign bus.match_cnt = match_cnt;
    assign bus.match_pos = match_pos;
endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb/tb_seq_scan_ctrl.sv - directed scoreboard bench for seq_scan_ctrl
module tb_seq_scan_ctrl;
    localparam int W  = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_scan_ctrl_if #(.WIDTH(W), .CW(CW)) bus();
    seq_scan_ctrl #(.WIDTH(W), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic b;
        logic h;
    } bit_t;

    int            n_cmp = 0;
    int            n_bad = 0;
    bit_t          exp_q[$];
    logic [CW-1:0] exp_cnt;
    logic [W-1:0]  exp_pos;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: a match ends on bit i when bits i-2..i read 1,0,1 in scan order.
    task automatic model(input logic [W-1:0] d);
        bit_t e;
        exp_cnt = '0;
        exp_pos = '0;
        for (int i = 0; i < W; i++) begin
            e.b = d[i];
            e.h = 1'b0;
            if (i >= 2) e.h = d[i] && !d[i-1] && d[i-2];
            if (e.h) begin
                exp_cnt    = exp_cnt + 1'b1;
                exp_pos[i] = 1'b1;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_busy"},      bus.busy,      0);
        chk({nm, "_done"},      bus.done,      0);
        chk({nm, "_ser_valid"}, bus.ser_valid, 0);
        chk({nm, "_ser_out"},   bus.ser_out,   0);
        chk({nm, "_hit"},       bus.hit,       0);
        chk({nm, "_cnt"},       bus.match_cnt, 0);
        chk({nm, "_pos"},       bus.match_pos, 0);
    endtask

    task automatic scan(input logic [W-1:0] d, input int hold_at, input int hold_len,
                        input int abort_at, input int rst_at, input bit keep_start,
                        input string nm);
        int            idx_c     = 0;
        int            e         = 0;
        int            hold_left = hold_len;
        bit            fin       = 1'b0;
        logic [CW-1:0] pc        = '0;
        logic [W-1:0]  pp        = '0;
        bit_t          x;
        model(d);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.data_in = d;
        @(posedge clk);
        #1;
        if (!keep_start) bus.start = 1'b0;
        bus.data_in = '0;
        chk({nm, "_busy_accept"}, bus.busy, 1);
        while (!fin && e < 100) begin
            @(negedge clk);
            bus.hold  = (idx_c == hold_at) && (hold_left > 0);
            bus.abort = (idx_c == abort_at);
            #1;
            if (bus.done) begin
                chk({nm, "_done_latency"}, e, W + hold_len);
                chk({nm, "_cnt"},          bus.match_cnt, exp_cnt);
                chk({nm, "_pos"},          bus.match_pos, exp_pos);
                chk({nm, "_bits_left"},    exp_q.size(), 0);
                chk({nm, "_done_busy"},    bus.busy, 0);
                chk({nm, "_done_valid"},   bus.ser_valid, 0);
                chk({nm, "_done_hit"},     bus.hit, 0);
                @(posedge clk);
                #1;
                chk({nm, "_done_pulse"},   bus.done, 0);
                chk({nm, "_idle_busy"},    bus.busy, 0);
                chk({nm, "_held_cnt"},     bus.match_cnt, exp_cnt);
                chk({nm, "_held_pos"},     bus.match_pos, exp_pos);
                fin = 1'b1;
            end else if (idx_c == rst_at) begin
                #1 rst = 1'b1;
                #1;
                chk_all_zero({nm, "_async_rst"});
                exp_q.delete();
                @(negedge clk);
                rst = 1'b0;
                fin = 1'b1;
            end else begin
                chk({nm, "_busy"},      bus.busy, 1);
                chk({nm, "_ser_valid"}, bus.ser_valid, !bus.hold && !bus.abort);
                chk({nm, "_ser_out"},   bus.ser_out, d[idx_c]);
                if (bus.ser_valid) begin
                    if (exp_q.size() == 0) begin
                        chk({nm, "_queue_underflow"}, 1, 0);
                    end else begin
                        x = exp_q.pop_front();
                        chk({nm, "_bit"}, bus.ser_out, x.b);
                        chk({nm, "_hit"}, bus.hit, x.h);
                        if (x.h) begin
                            pc        = pc + 1'b1;
                            pp[idx_c] = 1'b1;
                        end
                    end
                    idx_c++;
                end else begin
                    chk({nm, "_hit_gated"}, bus.hit, 0);
                end
                if (bus.hold) hold_left--;
                @(posedge clk);
                #1;
                e++;
                if (bus.abort) begin
                    bus.abort = 1'b0;
                    chk({nm, "_abort_busy"}, bus.busy, 0);
                    chk({nm, "_abort_done"}, bus.done, 0);
                    chk({nm, "_abort_cnt"},  bus.match_cnt, pc);
                    chk({nm, "_abort_pos"},  bus.match_pos, pp);
                    exp_q.delete();
                    @(posedge clk);
                    #1;
                    chk({nm, "_abort_no_done"}, bus.done, 0);
                    fin = 1'b1;
                end
            end
        end
        if (!fin) chk({nm, "_timeout"}, 1, 0);
        bus.hold  = 1'b0;
        bus.abort = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.data_in = '0;
        bus.hold    = 1'b0;
        bus.abort   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // hold/abort in IDLE must do nothing
        @(negedge clk);
        bus.hold  = 1'b1;
        bus.abort = 1'b1;
        #1;
        chk("idle_ser_valid", bus.ser_valid, 0);
        chk("idle_hit",       bus.hit, 0);
        @(posedge clk);
        #1;
        chk("idle_busy", bus.busy, 0);
        bus.hold  = 1'b0;
        bus.abort = 1'b0;

        scan(8'h05, -1, 0, -1, -1, 1'b0, "h05");
        chk("h05_cnt_const", bus.match_cnt, 1);
        chk("h05_pos_const", bus.match_pos, 8'h04);
        scan(8'hAD, -1, 0, -1, -1, 1'b0, "hAD");
        chk("hAD_cnt_const", bus.match_cnt, 3);
        chk("hAD_pos_const", bus.match_pos, 8'hA4);
        scan(8'h55, -1, 0, -1, -1, 1'b0, "h55");
        chk("h55_pos_const", bus.match_pos, 8'h54);
        scan(8'hFF, -1, 0, -1, -1, 1'b0, "hFF");
        chk("hFF_cnt_const", bus.match_cnt, 0);
        scan(8'h05, 1, 3, -1, -1, 1'b0, "hold");
        chk("hold_pos_const", bus.match_pos, 8'h04);
        scan(8'hAD, -1, 0, 4, -1, 1'b0, "abort");
        chk("abort_cnt_const", bus.match_cnt, 1);
        chk("abort_pos_const", bus.match_pos, 8'h04);
        scan(8'h05, -1, 0, -1, 5, 1'b0, "rst");
        scan(8'h05, -1, 0, -1, -1, 1'b0, "after_rst");

        // start held high: single scan, then re-accepted from the IDLE cycle
        scan(8'h3C, -1, 0, -1, -1, 1'b1, "held_start");
        @(posedge clk);
        #1;
        chk("held_start_reaccept", bus.busy, 1);
        bus.start = 1'b0;
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        chk("held_start_cleanup", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
